// File: rtl/motor_cmd_sequencer_pkg.sv
// motor_cmd_sequencer_pkg: direction codes, FSM encoding and ctrl word layout
// shared by the sequencer, the driver wrapper and the firmware headers.
package motor_cmd_sequencer_pkg;
   localparam logic [1:0] DIR_STOP  = 2'b00;
   localparam logic [1:0] DIR_FWD   = 2'b01;
   localparam logic [1:0] DIR_REV   = 2'b10;
   localparam logic [1:0] DIR_BRAKE = 2'b11;
   localparam int CTRL_DIR_LSB  = 16;
   localparam int CTRL_DUTY_LSB = 0;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RAMP   = 2'd1,
      ST_RAMPDN = 2'd2,
      ST_DEAD   = 2'd3
   } state_e;
   function automatic logic [31:0] pack_ctrl(input logic [1:0] dir, input logic [7:0] duty);
      return (32'(dir) << CTRL_DIR_LSB) | (32'(duty) << CTRL_DUTY_LSB);
   endfunction
   function automatic logic is_run(input logic [1:0] dir);
      return dir == DIR_FWD || dir == DIR_REV;
   endfunction
endpackage

// File: rtl/motor_cmd_sequencer_slew.sv
// motor_slew_step: one saturating step of cur toward tgt, landing exactly on tgt
// when the remaining distance is below step; 9-bit math so nothing wraps.
module motor_slew_step (
   input  logic [7:0] cur,
   input  logic [7:0] tgt,
   input  logic [7:0] step,
   output logic [7:0] nxt
);
   logic [8:0] up;
   logic [8:0] dn;
   always_comb begin
      up  = {1'b0, cur} + {1'b0, step};
      dn  = {1'b0, cur} - {1'b0, step};
      nxt = tgt > cur ? (up >= {1'b0, tgt} ? tgt : up[7:0]) :
            tgt < cur ? ((dn[8] || dn[7:0] <= tgt) ? tgt : dn[7:0]) : cur;
   end
endmodule

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: latches software motor commands and slews the driver
// toward them, with ramp-down plus brake dead-time on reversal and a stop watchdog.
module motor_cmd_sequencer
   import motor_cmd_sequencer_pkg::*;
#(
   parameter int unsigned RAMP_DIV    = 100000,
   parameter int unsigned RAMP_STEP   = 4,
   parameter int unsigned DEAD_CYCLES = 10000,
   parameter int unsigned WDT_CYCLES  = 50000000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_i,
   output logic        ctrl_we_o,
   output logic [31:0] ctrl_o,
   output logic        busy_o,
   output logic        wdt_o,
   output logic [1:0]  state_o
);
   localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
   localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
   localparam int WW = WDT_CYCLES > 1 ? $clog2(WDT_CYCLES) : 1;

   state_e        state, state_nx;
   logic [1:0]    cur_dir, cur_dir_nx, tgt_dir, cmd_dir;
   logic [7:0]    cur_duty, cur_duty_nx, tgt_duty, up_next, dn_next;
   logic [PW-1:0] pre_cnt;
   logic [DW-1:0] dead_cnt, dead_cnt_nx;
   logic [WW-1:0] wdt_cnt;
   logic          tick, reversing, reached;
   logic [31:0]   cur_word;
   logic          cmd_unused;

   assign cmd_dir    = cmd_i[CTRL_DIR_LSB +: 2];
   assign cmd_unused = ^{cmd_i[31:18], cmd_i[15:8]};
   assign tick       = pre_cnt == PW'(RAMP_DIV - 1);
   assign cur_word   = pack_ctrl(cur_dir, cur_duty);
   assign busy_o     = state != ST_IDLE || cur_dir != tgt_dir || cur_duty != tgt_duty;
   assign state_o    = state;

   motor_slew_step u_up (.cur(cur_duty), .tgt(tgt_duty), .step(8'(RAMP_STEP)), .nxt(up_next));
   motor_slew_step u_dn (.cur(cur_duty), .tgt(8'd0), .step(8'(RAMP_STEP)), .nxt(dn_next));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= ST_IDLE;
         cur_dir   <= DIR_STOP;
         cur_duty  <= '0;
         tgt_dir   <= DIR_STOP;
         tgt_duty  <= '0;
         pre_cnt   <= '0;
         dead_cnt  <= '0;
         wdt_cnt   <= '0;
         wdt_o     <= 1'b0;
         ctrl_o    <= '0;
         ctrl_we_o <= 1'b0;
      end else begin
         state     <= state_nx;
         cur_dir   <= cur_dir_nx;
         cur_duty  <= cur_duty_nx;
         dead_cnt  <= dead_cnt_nx;
         pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
         ctrl_o    <= cur_word;
         ctrl_we_o <= cur_word != ctrl_o;
         // stop/brake targets carry duty 0 so a settled output compares equal to them
         if (cmd_we_i) begin
            tgt_dir  <= cmd_dir;
            tgt_duty <= is_run(cmd_dir) ? cmd_i[CTRL_DUTY_LSB +: 8] : '0;
            wdt_cnt  <= '0;
            wdt_o    <= 1'b0;
         end else if (wdt_cnt == WW'(WDT_CYCLES - 1)) begin
            tgt_dir  <= DIR_STOP;
            tgt_duty <= '0;
            wdt_o    <= 1'b1;
         end else
            wdt_cnt <= wdt_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx    = state;
      cur_dir_nx  = cur_dir;
      cur_duty_nx = cur_duty;
      dead_cnt_nx = dead_cnt;
      reversing   = cur_duty != 0 && (tgt_dir == DIR_STOP ||
                    (is_run(cur_dir) && is_run(tgt_dir) && cur_dir != tgt_dir));
      reached     = cur_dir == tgt_dir && cur_duty == tgt_duty;
      unique case (state)
         ST_IDLE, ST_RAMP: begin
            if (tgt_dir == DIR_BRAKE) begin
               cur_dir_nx  = DIR_BRAKE;
               cur_duty_nx = '0;
               state_nx    = ST_IDLE;
            end else if (reversing)
               state_nx = ST_RAMPDN;
            else if (tgt_dir == DIR_STOP) begin
               cur_dir_nx = DIR_STOP;
               state_nx   = ST_IDLE;
            end else if (reached)
               state_nx = ST_IDLE;
            else if (state == ST_IDLE)
               state_nx = ST_RAMP;
            else if (tick) begin
               // direction switches on the first step, so a ramp from rest never strobes duty 0
               cur_dir_nx  = tgt_dir;
               cur_duty_nx = up_next;
            end
         end
         ST_RAMPDN: begin
            if (cur_duty != 0)
               cur_duty_nx = tick ? dn_next : cur_duty;
            else if (tgt_dir == DIR_STOP) begin
               cur_dir_nx = DIR_STOP;
               state_nx   = ST_IDLE;
            end else begin
               cur_dir_nx  = DIR_BRAKE;
               dead_cnt_nx = DW'(DEAD_CYCLES - 1);
               state_nx    = ST_DEAD;
            end
         end
         ST_DEAD: begin
            if (dead_cnt != 0)
               dead_cnt_nx = dead_cnt - 1'b1;
            else begin
               // first ramp step leaves DEAD directly so brake lasts exactly DEAD_CYCLES
               cur_dir_nx  = tgt_dir;
               cur_duty_nx = is_run(tgt_dir) ? up_next : '0;
               state_nx    = is_run(tgt_dir) ? ST_RAMP : ST_IDLE;
            end
         end
      endcase
   end
endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb_motor_cmd_sequencer: randomized and directed checks of the sequencer against
// a transaction-level model of the strobed ctrl word sequence.
module tb_motor_cmd_sequencer;
   localparam int RD = 4;
   localparam int RS = 4;
   localparam int DC = 8;
   localparam int WD = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd = '0;
   logic        ctrl_we;
   logic [31:0] ctrl_o;
   logic        busy;
   logic        wdt;
   logic [1:0]  state_o;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int t_wr = 0;
   int strobe_bad = 0;
   logic [31:0] prev = '0;
   logic [31:0] last_cmd = '0;
   logic [31:0] obs_v[$];
   int          obs_t[$];
   logic [31:0] exp_q[$];
   logic [1:0]  m_dir = 2'd0;
   logic [7:0]  m_duty = 8'd0;

   motor_cmd_sequencer #(.RAMP_DIV(RD), .RAMP_STEP(RS), .DEAD_CYCLES(DC), .WDT_CYCLES(WD)) dut (
      .clk_i(clk), .rst_i(rst_n), .cmd_we_i(cmd_we), .cmd_i(cmd),
      .ctrl_we_o(ctrl_we), .ctrl_o(ctrl_o), .busy_o(busy), .wdt_o(wdt), .state_o(state_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) prev = '0;
      else begin
         if (ctrl_we && ctrl_o === prev) strobe_bad++;
         if (!ctrl_we && ctrl_o !== prev) strobe_bad++;
         if (ctrl_we) begin
            obs_v.push_back(ctrl_o);
            obs_t.push_back(cyc);
         end
         prev = ctrl_o;
      end
   end

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
      return (i >= 0 && i < q.size()) ? q[i] : 32'hxxxxxxxx;
   endfunction

   function automatic int first_diff();
      int n = obs_v.size() > exp_q.size() ? obs_v.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (q_at(obs_v, i) !== q_at(exp_q, i)) return i;
      return -1;
   endfunction

   function automatic bit run_dir(input logic [1:0] d);
      return d == 2'd1 || d == 2'd2;
   endfunction

   task automatic push(input logic [1:0] d, input logic [7:0] u);
      exp_q.push_back({14'b0, d, 8'b0, u});
   endtask

   task automatic ramp_to(input logic [1:0] td, input logic [7:0] tu);
      if (m_duty == tu) begin
         if (m_dir != td) push(td, tu);
      end else
         while (m_duty != tu) begin
            int diff = int'(tu) - int'(m_duty);
            m_duty = diff > RS ? m_duty + 8'(RS) : diff < -RS ? m_duty - 8'(RS) : tu;
            push(td, m_duty);
         end
      m_dir = td;
   endtask

   // expected strobe sequence for a command issued from a settled output
   task automatic model_expect(input logic [31:0] c);
      logic [1:0] td = c[17:16];
      logic [7:0] tu = run_dir(td) ? c[7:0] : 8'd0;
      exp_q.delete();
      if (td == 2'd3) begin
         if (!(m_dir == 2'd3 && m_duty == 0)) push(2'd3, 8'd0);
         m_dir = 2'd3;
         m_duty = 8'd0;
      end else if (m_duty != 0 && (td == 2'd0 || (run_dir(m_dir) && m_dir != td))) begin
         while (m_duty != 0) begin
            m_duty = m_duty > RS ? m_duty - 8'(RS) : 8'd0;
            push(m_dir, m_duty);
         end
         if (td == 2'd0) begin
            m_dir = 2'd0;
            push(2'd0, 8'd0);
         end else begin
            m_dir = 2'd3;
            push(2'd3, 8'd0);
            ramp_to(td, tu);
         end
      end else if (td == 2'd0) begin
         if (m_dir != 2'd0) push(2'd0, 8'd0);
         m_dir = 2'd0;
      end else
         ramp_to(td, tu);
   endtask

   task automatic send(input logic [31:0] c);
      @(negedge clk);
      cmd = c;
      cmd_we = 1'b1;
      last_cmd = c;
      @(negedge clk);
      cmd_we = 1'b0;
      #1 t_wr = cyc;
   endtask

   task automatic settle(input bit refresh, output bit to);
      int quiet = 0;
      to = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         quiet = busy ? 0 : quiet + 1;
         if (quiet >= 3) begin
            to = 1'b0;
            break;
         end
         if (refresh && i % 100 == 99) send(last_cmd);
      end
   endtask

   task automatic apply(input logic [31:0] c, output bit to);
      model_expect(c);
      obs_v.delete();
      obs_t.delete();
      send(c);
      settle(1'b1, to);
   endtask

   task automatic test_reset();
      n_chk++;
      if ({ctrl_o, ctrl_we, busy, wdt, state_o} !== 37'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: ctrl=%h we=%b busy=%b wdt=%b state=%0d, want all 0", ctrl_o, ctrl_we, busy, wdt, state_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if (obs_v.size() != 0 || ctrl_o !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_idle: %0d strobes ctrl=%h, want 0 strobes ctrl=0", obs_v.size(), ctrl_o);
      end
   endtask

   task automatic test_ramp_up();
      bit to;
      int d;
      apply(32'h0001_0010, to);
      n_chk++;
      if (to) begin n_fail++; $display("FAIL ramp_up_settle: busy still %b, want 0", busy); end
      d = first_diff();
      n_chk++;
      if (d >= 0) begin
         n_fail++;
         $display("FAIL ramp_up_seq: strobe %0d got %h want %h (%0d strobes, want %0d)", d, q_at(obs_v, d), q_at(exp_q, d), obs_v.size(), exp_q.size());
      end
      for (int i = 1; i < obs_t.size(); i++) begin
         n_chk++;
         if (obs_t[i] - obs_t[i-1] != RD) begin
            n_fail++;
            $display("FAIL ramp_up_spacing: step %0d after %0d cycles, want %0d", i, obs_t[i] - obs_t[i-1], RD);
         end
      end
      n_chk++;
      if (state_o !== 2'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ramp_up_idle: state=%0d busy=%b, want 0 0", state_o, busy);
      end
   endtask

   task automatic test_reversal();
      bit to;
      int d;
      int k = -1;
      apply(32'h0002_0008, to);
      n_chk++;
      if (to) begin n_fail++; $display("FAIL reversal_settle: busy still %b, want 0", busy); end
      d = first_diff();
      n_chk++;
      if (d >= 0) begin
         n_fail++;
         $display("FAIL reversal_seq: strobe %0d got %h want %h (%0d strobes, want %0d)", d, q_at(obs_v, d), q_at(exp_q, d), obs_v.size(), exp_q.size());
      end
      foreach (obs_v[i]) if (obs_v[i] === 32'h0003_0000 && k < 0) k = i;
      n_chk++;
      if (k < 0 || k + 1 >= obs_t.size()) begin
         n_fail++;
         $display("FAIL reversal_dead: brake word index %0d of %0d strobes, want brake then ramp", k, obs_t.size());
      end else if (obs_t[k+1] - obs_t[k] != DC) begin
         n_fail++;
         $display("FAIL reversal_dead: brake held %0d cycles, want %0d", obs_t[k+1] - obs_t[k], DC);
      end
   endtask

   task automatic test_brake();
      bit to;
      int d;
      apply(32'h0001_0010, to);
      apply(32'h0003_00FF, to);
      d = first_diff();
      n_chk++;
      if (d >= 0) begin
         n_fail++;
         $display("FAIL brake_seq: strobe %0d got %h want %h (%0d strobes, want %0d)", d, q_at(obs_v, d), q_at(exp_q, d), obs_v.size(), exp_q.size());
      end
      n_chk++;
      if (obs_t.size() != 1 || obs_t[0] - t_wr != 2) begin
         n_fail++;
         $display("FAIL brake_latency: %0d strobes, first %0d cycles after write, want 1 strobe 2 cycles", obs_t.size(), obs_t.size() ? obs_t[0] - t_wr : -1);
      end
   endtask

   task automatic test_saturate();
      bit to;
      int d;
      logic [31:0] seq[4] = '{32'h0001_00FC, 32'h0001_00FE, 32'h0001_0002, 32'h0001_0003};
      foreach (seq[j]) begin
         apply(seq[j], to);
         d = first_diff();
         n_chk++;
         if (to || d >= 0) begin
            n_fail++;
            $display("FAIL saturate_%0d: timeout=%b strobe %0d got %h want %h (%0d strobes, want %0d)", j, to, d, q_at(obs_v, d), q_at(exp_q, d), obs_v.size(), exp_q.size());
         end
      end
   endtask

   task automatic test_watchdog();
      bit to;
      int d;
      int k = 0;
      apply(32'h0001_0010, to);
      obs_v.delete();
      obs_t.delete();
      send(32'h0001_0010);
      while (!wdt && k < 2 * WD) begin
         @(negedge clk);
         k++;
      end
      n_chk++;
      if (k != WD) begin
         n_fail++;
         $display("FAIL wdt_expiry: wdt_o=%b after %0d cycles, want 1 after %0d", wdt, k, WD);
      end
      model_expect(32'h0000_0000);
      settle(1'b0, to);
      d = first_diff();
      n_chk++;
      if (to || d >= 0) begin
         n_fail++;
         $display("FAIL wdt_stop_seq: timeout=%b strobe %0d got %h want %h (%0d strobes, want %0d)", to, d, q_at(obs_v, d), q_at(exp_q, d), obs_v.size(), exp_q.size());
      end
      n_chk++;
      if (wdt !== 1'b1 || ctrl_o !== 32'd0) begin
         n_fail++;
         $display("FAIL wdt_sticky: wdt=%b ctrl=%h, want 1 00000000", wdt, ctrl_o);
      end
      apply(32'h0001_0004, to);
      n_chk++;
      if (wdt !== 1'b0 || ctrl_o !== 32'h0001_0004) begin
         n_fail++;
         $display("FAIL wdt_clear: wdt=%b ctrl=%h, want 0 00010004", wdt, ctrl_o);
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      @(negedge clk);
      cmd = 32'h0001_0040;
      cmd_we = 1'b1;
      @(negedge clk);
      cmd = 32'h0002_0020;
      last_cmd = cmd;
      @(negedge clk);
      cmd_we = 1'b0;
      settle(1'b1, to);
      m_dir = 2'd2;
      m_duty = 8'h20;
      n_chk++;
      if (to || ctrl_o !== 32'h0002_0020 || state_o !== 2'd0) begin
         n_fail++;
         $display("FAIL back_to_back: timeout=%b ctrl=%h state=%0d, want 00020020 state 0", to, ctrl_o, state_o);
      end
   endtask

   task automatic test_random();
      bit to;
      int d;
      logic [31:0] c;
      for (int j = 0; j < 12; j++) begin
         c = $urandom;
         c[17:16] = 2'($urandom_range(0, 3));
         if (j % 4 == 3) c[7:0] = (j % 8 == 3) ? 8'hFF : 8'h00;
         apply(c, to);
         d = first_diff();
         n_chk++;
         if (to || d >= 0) begin
            n_fail++;
            $display("FAIL random_%0d cmd %h: timeout=%b strobe %0d got %h want %h (%0d strobes, want %0d)", j, c, to, d, q_at(obs_v, d), q_at(exp_q, d), obs_v.size(), exp_q.size());
         end
      end
   endtask

   task automatic test_reset_dead();
      bit to;
      int k = 0;
      apply(32'h0001_0010, to);
      send(32'h0002_0008);
      while (state_o !== 2'd3 && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_chk++;
      if (state_o !== 2'd3) begin n_fail++; $display("FAIL reset_dead_reach: state=%0d, want 3", state_o); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (ctrl_o !== 32'd0 || state_o !== 2'd0 || wdt !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: ctrl=%h state=%0d wdt=%b busy=%b, want 0 0 0 0", ctrl_o, state_o, wdt, busy);
      end
      m_dir = 2'd0;
      m_duty = 8'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      obs_v.delete();
      obs_t.delete();
      repeat (20) @(negedge clk);
      n_chk++;
      if (obs_v.size() != 0 || ctrl_o !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_quiet: %0d strobes ctrl=%h, want 0 strobes ctrl=0", obs_v.size(), ctrl_o);
      end
   endtask

   task automatic test_strobe_integrity();
      n_chk++;
      if (strobe_bad != 0) begin
         n_fail++;
         $display("FAIL strobe_integrity: %0d cycles where ctrl_we_o disagreed with a ctrl_o change, want 0", strobe_bad);
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_ramp_up();
      test_reversal();
      test_brake();
      test_saturate();
      test_watchdog();
      test_back_to_back();
      test_random();
      test_reset_dead();
      test_strobe_integrity();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
Sits between the MMIO store path (motor-control address) and the TB6612FNG driver wrapper. Latches software motor commands as a target, then ramps duty toward that target at a fixed slew rate. On a forward/reverse reversal it inserts a ramp-down and a timed brake dead-time. A watchdog forces a controlled stop if software stops writing commands, so the driver never sees abrupt reversals or stale commands.

Parameters:
RAMP_DIV, 100000, clock cycles per ramp tick (1 ms at 100 MHz)
RAMP_STEP, 4, duty LSBs changed per ramp tick
DEAD_CYCLES, 10000, brake dead-time cycles between opposite directions
WDT_CYCLES, 50000000, cycles without a command write before the forced stop

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; asynchronous, active-low
cmd_we_i  in  1  store to the motor-control address; one-cycle pulse
cmd_i  in  32  [17:16] dir {in1,in2}, [7:0] duty; all other bits ignored
ctrl_we_o  out  1  one-cycle strobe to driver we_i
ctrl_o  out  32  {14'b0, dir[1:0], 8'b0, duty[7:0]} to driver ctrl_i
busy_o  out  1  current output differs from target, or not in IDLE
wdt_o  out  1  sticky watchdog-expired flag
state_o  out  2  current FSM state, for MMIO readback

Behaviour:
- Direction codes: 00 stop, 01 forward, 10 reverse, 11 brake.
- Reset (asynchronous, rst_i=0):
  - cur_dir=00, cur_duty=0, tgt=0, state=IDLE.
  - ctrl_o=0, ctrl_we_o=0, busy_o=0, wdt_o=0.
  - All counters cleared.
  - A reset mid-ramp or mid-dead-time aborts immediately to these values.
- Command write (cmd_we_i=1): tgt_dir/tgt_duty <= cmd_i fields, watchdog counter cleared, wdt_o cleared.
  - Accepted in every state; the newest write wins.
  - Takes effect in the next cycle's decision.
- Ramp tick:
  - Free-running counter counts 0..RAMP_DIV-1; tick=1 on the cycle it wraps to 0.
  - Counter is not reset by writes.
- FSM states: IDLE(0), RAMP(1), RAMPDN(2), DEAD(3).
  - IDLE:
    - tgt_dir=11: cur_dir=11, cur_duty=0 immediately, next cycle; stay IDLE. Brake bypasses ramping.
    - tgt_dir==cur_dir, or cur_dir in {00,11}, or cur_duty==0, with target not yet reached: go to RAMP; cur_dir <= tgt_dir when tgt_dir is not 00.
    - tgt_dir is the opposite of cur_dir (01<->10) and cur_duty>0: go to RAMPDN.
    - tgt_dir=00 and cur_duty>0: go to RAMPDN.
  - RAMP: on each tick move cur_duty toward tgt_duty by RAMP_STEP.
    - If |tgt_duty-cur_duty|<RAMP_STEP, set cur_duty=tgt_duty.
    - No 8-bit wrap: arithmetic is 9-bit, saturating at 0 and 255.
    - When equal, return to IDLE.
    - A target change during RAMP is re-evaluated: an opposite or stop direction goes to RAMPDN.
  - RAMPDN: on each tick cur_duty decreases by RAMP_STEP, saturating at 0.
    - At 0 with tgt_dir=00: cur_dir=00, go to IDLE.
    - At 0 otherwise: cur_dir=11, load the dead counter, go to DEAD.
  - DEAD: hold dir=11, duty=0 for exactly DEAD_CYCLES cycles.
    - Then cur_dir=tgt_dir and go to RAMP, or to IDLE if tgt_dir is 00 or 11.
- Watchdog: counter increments every cycle and is cleared by a write.
  - At WDT_CYCLES-1: wdt_o=1 (sticky), tgt <= {00, 0}, which triggers the normal stop sequence.
  - Watchdog expiry and a write in the same cycle: the write wins and wdt_o stays 0.
- Output: ctrl_o is registered from cur_dir/cur_duty.
  - ctrl_we_o=1 for exactly one cycle in the same cycle ctrl_o takes a new value.
  - No strobe when the value is unchanged.
- busy_o = (state!=IDLE) | (cur!=tgt).

Decomposition:
- Shared package: direction codes (DIR_STOP/FWD/REV/BRAKE), state encoding, and the ctrl word field offsets (dir at 17:16, duty at 7:0). The driver wrapper and firmware headers use the same offsets.
- One natural sub-module: motor_slew_step, a combinational saturating step toward the target (cur, tgt, step -> next).
- Prescaler, watchdog and FSM stay in the top module.

Test Plan (RAMP_DIV=4, RAMP_STEP=4, DEAD_CYCLES=8, WDT_CYCLES=200):
- Write 0x0001_0010 from reset -> ctrl_o steps 0x0001_0004, 0x0001_0008, 0x0001_000C, 0x0001_0010 one per tick; 4 ctrl_we_o pulses, then IDLE and busy_o=0.
- At forward duty 0x10, write 0x0002_0008 -> duty ramps down to 0, then ctrl_o=0x0003_0000 held exactly 8 cycles, then 0x0002_0004, 0x0002_0008.
- At forward duty 0x10, write 0x0003_00FF -> next cycle ctrl_o=0x0003_0000 with a single strobe, no ramp.
- Write duty 0xFE while current is 0xFC -> single step to 0xFE, no overflow past 0xFF; write 0x0001_0003 from 0x0001_0002 -> one step to 0x03.
- No writes for 200 cycles while forward at 0x10 -> wdt_o=1, ramp down to 0x0000_0000; the next write clears wdt_o.
- Assert rst_i=0 during DEAD -> ctrl_o=0, state_o=0, wdt_o=0 asynchronously; after release, no strobe until a new write.
